bp_1bit_ctrl: RTL and testbench
===============================

// Module: bp_1bit_ctrl
// PURPOSE
//  IF-stage 1-bit branch predictor controller; drives the BTB RAM (shared rd/wr address port).
//  - Fetch side: indexes the BTB with the fetch PC, checks the local valid/tag/history table,
//    and produces the predicted next PC.
//  - EX side: takes resolved branches, updates the table, writes the BTB, and flags mispredicts.
// PARAMETERS
//  INDEX_W  10  table/BTB index bits (entries = 2**INDEX_W); index = pc[INDEX_W+1:2]
//  TAG_W    20  tag bits; tag = pc[INDEX_W+2 +: TAG_W] (INDEX_W+2+TAG_W <= 32)
// PORTS
//  i_clk           in   1        clock; all state updates on posedge
//  i_rst           in   1        synchronous reset, active-high
//  i_if_pc         in   32       current fetch PC
//  i_btb_target    in   32       BTB read data (valid same cycle; BTB reads on negedge)
//  o_btb_addr      out  INDEX_W  BTB address: EX index when o_btb_wren, else IF index
//  o_btb_wren      out  1        BTB write enable
//  o_btb_wdata     out  32       BTB write data (= i_ex_target)
//  o_pred_taken    out  1        fetch prediction: taken
//  o_pred_pc       out  32       predicted next PC
//  i_ex_valid      in   1        EX holds a valid instruction
//  i_ex_is_branch  in   1        EX instr is a conditional branch or jal
//  i_ex_pc         in   32       EX instruction PC
//  i_ex_taken      in   1        resolved direction
//  i_ex_target     in   32       resolved target
//  i_ex_pred_taken in   1        o_pred_taken piped IF->EX
//  i_ex_pred_pc    in   32       o_pred_pc piped IF->EX
//  o_mispredict    out  1        flush IF/ID and redirect this cycle
//  o_redirect_pc   out  32       correct next PC when o_mispredict
// BEHAVIOUR
//  - State: valid[], tag[], hist[] register arrays, 2**INDEX_W entries each.
//  - Reset: valid/hist all 0, tags 0. Outputs with no active inputs after reset:
//    o_pred_taken=0, o_pred_pc=i_if_pc+4, o_btb_wren=0, o_mispredict=0.
//  - Predict (combinational): hit = valid[iidx] && tag[iidx]==itag;
//    o_pred_taken = hit && hist[iidx] && !o_btb_wren;
//    o_pred_pc = o_pred_taken ? i_btb_target : i_if_pc+4.
//  - upd = i_ex_valid && i_ex_is_branch.
//    o_btb_wren = upd && i_ex_taken; o_btb_wdata = i_ex_target.
//    Not-taken updates leave the stored target intact.
//  - Posedge when upd: valid[e]<=1; tag[e]<=etag; hist[e]<=i_ex_taken.
//  - Alias: i_ex_valid && !i_ex_is_branch && i_ex_pred_taken -> valid[e]<=0 and mispredict.
//  - Mispredict (combinational, valid only when i_ex_valid):
//    upd && (i_ex_pred_taken != i_ex_taken
//            || (i_ex_taken && i_ex_pred_pc != i_ex_target))
//    || alias case.
//    o_redirect_pc = (upd && i_ex_taken) ? i_ex_target : i_ex_pc+4.
//  - Port conflict: when o_btb_wren=1, the BTB port serves the write, so the fetch prediction
//    is forced not-taken. This is correct-by-fallback and costs no extra cycle.
//  - Same index in IF and EX in one cycle: IF sees the pre-update table; the update is
//    visible the next cycle.
//  - Arithmetic: PC+4 is 32-bit, wraps 0xFFFFFFFC -> 0x00000000.
//  - Reset mid-operation: the table clears on the next posedge; no pending writes are kept.
// CONFIGURATION
//  BP_STATS_EN defined:
//    - Adds out o_br_cnt[31:0] and o_mp_cnt[31:0], both cleared by i_rst.
//    - o_br_cnt += 1 per upd cycle; o_mp_cnt += 1 per o_mispredict cycle.
//    - Both counters saturate at 0xFFFFFFFF.
//  BP_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Cold miss: after reset, i_if_pc=0x100 -> o_pred_taken=0, o_pred_pc=0x104, o_btb_addr=0x040.
//  2 Train+hit, step 1: EX branch at pc=0x100, taken, target=0x200, pred_taken=0
//    -> o_mispredict=1, redirect=0x200, o_btb_wren=1, addr=0x040.
//  3 Train+hit, step 2: a later fetch of 0x100 with BTB returning 0x200
//    -> o_pred_taken=1, o_pred_pc=0x200.
//  4 Flip: same branch resolves not-taken with pred_taken=1 -> mispredict, redirect=0x104,
//    o_btb_wren=0; the next fetch of 0x100 predicts 0x104.
//  5 Alias: fetch of 0x1100 (same index, different tag) -> not taken.
//    Non-branch in EX with pred_taken=1 at pc=0x300 -> mispredict, redirect=0x304, entry invalidated.
//  6 Conflict/reset: taken update in EX while IF hits a trained entry -> o_pred_taken=0 that cycle.
//    Assert i_rst for one cycle, then retrain-free fetch of 0x100 -> not taken.
//    With BP_STATS_EN, counters read 0.

Source files
------------

// File: rtl/bp_1bit_ctrl_if.sv
// BTB RAM port bundle for the 1-bit branch predictor controller.
// A single shared address serves both the fetch-side read and the EX-side write.
// The controller is the master and the BTB RAM is the slave.
interface bp_1bit_ctrl_if #(
  parameter int INDEX_W = 10
);
  logic [INDEX_W-1:0] o_btb_addr;
  logic               o_btb_wren;
  logic [31:0]        o_btb_wdata;
  logic [31:0]        i_btb_target;

  modport master (
    output o_btb_addr,
    output o_btb_wren,
    output o_btb_wdata,
    input  i_btb_target
  );

  modport slave (
    input  o_btb_addr,
    input  o_btb_wren,
    input  o_btb_wdata,
    output i_btb_target
  );
endinterface

// File: rtl/bp_1bit_ctrl.sv
// IF-stage 1-bit branch predictor controller.
// - The fetch side indexes the BTB and the local valid/tag/history table.
//   From these it forms the predicted next PC.
// - The EX side trains the table, writes taken targets into the BTB, and flags mispredicts.
// Optional build macro BP_STATS_EN adds two saturating counters:
//   o_br_cnt counts resolved branches and o_mp_cnt counts mispredict cycles.
module bp_1bit_ctrl #(
  parameter int INDEX_W = 10,
  parameter int TAG_W   = 20
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_if_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_pc,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_branch,
  input  logic [31:0] i_ex_pc,
  input  logic        i_ex_taken,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_pred_pc,
  output logic        o_mispredict,
  output logic [31:0] o_redirect_pc,
`ifdef BP_STATS_EN
  output logic [31:0] o_br_cnt,
  output logic [31:0] o_mp_cnt,
`endif
  bp_1bit_ctrl_if.master btb
);

  localparam int ENTRIES = 1 << INDEX_W;

  // Predictor table, one bit of direction history per entry
  logic               r_valid [ENTRIES];
  logic [TAG_W-1:0]   r_tag   [ENTRIES];
  logic               r_hist  [ENTRIES];

  logic [INDEX_W-1:0] w_iidx;
  logic [TAG_W-1:0]   w_itag;
  logic [INDEX_W-1:0] w_eidx;
  logic [TAG_W-1:0]   w_etag;
  logic               w_hit;
  logic               w_upd;
  logic               w_alias;
  logic               w_wren;
  logic               w_unused_bits;

  assign w_iidx = i_if_pc[INDEX_W+1:2];
  assign w_itag = i_if_pc[INDEX_W+2 +: TAG_W];
  assign w_eidx = i_ex_pc[INDEX_W+1:2];
  assign w_etag = i_ex_pc[INDEX_W+2 +: TAG_W];
  // PCs are word aligned, so the byte-offset bits carry no information
  assign w_unused_bits = ^{i_if_pc[1:0], i_ex_pc[1:0]};

  // EX-side resolution
  assign w_upd   = i_ex_valid && i_ex_is_branch;
  // A non-branch that was predicted taken means the table entry aliased onto it
  assign w_alias = i_ex_valid && !i_ex_is_branch && i_ex_pred_taken;
  assign w_wren  = w_upd && i_ex_taken;

  // BTB port: a pending write owns the shared address
  always_comb begin
    btb.o_btb_wren  = w_wren;
    btb.o_btb_wdata = i_ex_target;
    btb.o_btb_addr  = w_wren ? w_eidx : w_iidx;
  end

  // Fetch prediction reads the pre-update table.
  // The BTB read is lost whenever a write takes the port, so prediction falls back to not-taken.
  always_comb begin
    w_hit        = r_valid[w_iidx] && (r_tag[w_iidx] == w_itag);
    o_pred_taken = w_hit && r_hist[w_iidx] && !w_wren;
    o_pred_pc    = o_pred_taken ? btb.i_btb_target : (i_if_pc + 32'd4);
  end

  // Mispredict detection and redirect target
  always_comb begin
    o_mispredict  = (w_upd && ((i_ex_pred_taken != i_ex_taken) ||
                               (i_ex_taken && (i_ex_pred_pc != i_ex_target))))
                    || w_alias;
    o_redirect_pc = w_wren ? i_ex_target : (i_ex_pc + 32'd4);
  end

  // Table training on resolved branches, invalidation on aliased non-branches
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_hist[i]  <= 1'b0;
      end
    end else if (w_upd) begin
      r_valid[w_eidx] <= 1'b1;
      r_tag[w_eidx]   <= w_etag;
      r_hist[w_eidx]  <= i_ex_taken;
    end else if (w_alias) begin
      r_valid[w_eidx] <= 1'b0;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_br_cnt;
  logic [31:0] r_mp_cnt;

  // Saturating branch and mispredict counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_br_cnt <= '0;
      r_mp_cnt <= '0;
    end else begin
      if (w_upd && (r_br_cnt != 32'hFFFF_FFFF))
        r_br_cnt <= r_br_cnt + 32'd1;
      if (o_mispredict && (r_mp_cnt != 32'hFFFF_FFFF))
        r_mp_cnt <= r_mp_cnt + 32'd1;
    end
  end

  assign o_br_cnt = r_br_cnt;
  assign o_mp_cnt = r_mp_cnt;
`endif

endmodule

// File: tb/tb_bp_1bit_ctrl.sv
// Testbench for bp_1bit_ctrl.
// Directed vectors carry hand-computed expected outputs.
// The driver pushes each expectation into exp_q.
// A negedge monitor pops and compares against the live outputs.
module tb_bp_1bit_ctrl;

  localparam int INDEX_W = 10;
  localparam int VW      = 1 + 32 + INDEX_W + 1 + 32 + 1 + 32;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_pc;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] br_cnt;
  logic [31:0] mp_cnt;
`endif

  bp_1bit_ctrl_if #(.INDEX_W(INDEX_W)) btb_if ();

  bp_1bit_ctrl #(.INDEX_W(INDEX_W), .TAG_W(20)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_if_pc         (if_pc),
    .o_pred_taken    (pred_taken),
    .o_pred_pc       (pred_pc),
    .i_ex_valid      (ex_valid),
    .i_ex_is_branch  (ex_is_branch),
    .i_ex_pc         (ex_pc),
    .i_ex_taken      (ex_taken),
    .i_ex_target     (ex_target),
    .i_ex_pred_taken (ex_pred_taken),
    .i_ex_pred_pc    (ex_pred_pc),
    .o_mispredict    (mispredict),
    .o_redirect_pc   (redirect_pc),
`ifdef BP_STATS_EN
    .o_br_cnt        (br_cnt),
    .o_mp_cnt        (mp_cnt),
`endif
    .btb             (btb_if.master)
  );

  // Scoreboard state
  logic [VW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int vec_no   = 0;

  // Driver: apply one cycle of stimulus just after posedge and queue its expectation
  task automatic drive(
    input logic        v_rst,
    input logic [31:0] v_if_pc,
    input logic [31:0] v_btb,
    input logic        v_exv,
    input logic        v_exb,
    input logic [31:0] v_expc,
    input logic        v_extk,
    input logic [31:0] v_extgt,
    input logic        v_exptk,
    input logic [31:0] v_exppc,
    input logic        e_tk,
    input logic [31:0] e_pc,
    input logic [9:0]  e_addr,
    input logic        e_wren,
    input logic        e_mp,
    input logic [31:0] e_redir
  );
    @(posedge clk);
    #1;
    rst                 = v_rst;
    if_pc               = v_if_pc;
    btb_if.i_btb_target = v_btb;
    ex_valid            = v_exv;
    ex_is_branch        = v_exb;
    ex_pc               = v_expc;
    ex_taken            = v_extk;
    ex_target           = v_extgt;
    ex_pred_taken       = v_exptk;
    ex_pred_pc          = v_exppc;
    exp_q.push_back({e_tk, e_pc, e_addr, e_wren, v_extgt, e_mp, e_redir});
  endtask

  // Idle EX stage: EX pc 0 means a redirect of 0x4 and a write-data echo of 0
  task automatic fetch(
    input logic [31:0] v_if_pc,
    input logic [31:0] v_btb,
    input logic        e_tk,
    input logic [31:0] e_pc,
    input logic [9:0]  e_addr
  );
    drive(1'b0, v_if_pc, v_btb, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
          e_tk, e_pc, e_addr, 1'b0, 1'b0, 32'h4);
  endtask

  // Monitor: compare the live outputs with the oldest expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [VW-1:0] e;
      logic [VW-1:0] a;
      e = exp_q.pop_front();
      a = {pred_taken, pred_pc, btb_if.o_btb_addr, btb_if.o_btb_wren, btb_if.o_btb_wdata,
           mispredict, redirect_pc};
      vec_no++;
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL vec%0d: got tk=%0b pc=%h addr=%h wren=%0b wd=%h mp=%0b rd=%h, want tk=%0b pc=%h addr=%h wren=%0b wd=%h mp=%0b rd=%h",
                 vec_no, a[108], a[107:76], a[75:66], a[65], a[64:33], a[32], a[31:0],
                 e[108], e[107:76], e[75:66], e[65], e[64:33], e[32], e[31:0]);
      end
    end
  end

  initial begin
    if_pc = 32'h0; btb_if.i_btb_target = 32'h0;
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_pc = 32'h0; ex_taken = 1'b0;
    ex_target = 32'h0; ex_pred_taken = 1'b0; ex_pred_pc = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);

    // 1 cold miss
    fetch(32'h100, 32'hDEAD, 1'b0, 32'h104, 10'h040);
    // 2 train: taken to 0x200, predicted not-taken
    drive(1'b0, 32'h100, 32'h200, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104,
          1'b0, 32'h104, 10'h040, 1'b1, 1'b1, 32'h200);
    // 3 hit on trained entry
    fetch(32'h100, 32'h200, 1'b1, 32'h200, 10'h040);
    // 4 flip to not-taken; IF still sees the pre-update entry
    drive(1'b0, 32'h100, 32'h200, 1'b1, 1'b1, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200,
          1'b1, 32'h200, 10'h040, 1'b0, 1'b1, 32'h104);
    // 5 after flip, fall through
    fetch(32'h100, 32'h200, 1'b0, 32'h104, 10'h040);
    // 6 retrain taken; the write owns the address
    drive(1'b0, 32'h180, 32'h999, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104,
          1'b0, 32'h184, 10'h040, 1'b1, 1'b1, 32'h200);
    // 7 alias fetch: same index, different tag
    fetch(32'h1100, 32'h200, 1'b0, 32'h1104, 10'h040);
    // 8 correct taken prediction; a port conflict forces IF not-taken
    drive(1'b0, 32'h100, 32'h200, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200,
          1'b0, 32'h104, 10'h040, 1'b1, 1'b0, 32'h200);
    // 9 right direction, wrong target
    drive(1'b0, 32'h500, 32'h0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h240, 1'b1, 32'h200,
          1'b0, 32'h504, 10'h040, 1'b1, 1'b1, 32'h240);
    // 10 train branch at 0x300
    drive(1'b0, 32'h300, 32'h380, 1'b1, 1'b1, 32'h300, 1'b1, 32'h380, 1'b0, 32'h304,
          1'b0, 32'h304, 10'h0C0, 1'b1, 1'b1, 32'h380);
    // 11 hit at 0x300
    fetch(32'h300, 32'h380, 1'b1, 32'h380, 10'h0C0);
    // 12 non-branch predicted taken at 0x300: alias mispredict
    drive(1'b0, 32'h300, 32'h380, 1'b1, 1'b0, 32'h300, 1'b0, 32'h0, 1'b1, 32'h380,
          1'b1, 32'h380, 10'h0C0, 1'b0, 1'b1, 32'h304);
    // 13 entry invalidated
    fetch(32'h300, 32'h380, 1'b0, 32'h304, 10'h0C0);
    // 14 non-branch predicted not-taken: no mispredict; IF hits the 0x240 target
    drive(1'b0, 32'h100, 32'h240, 1'b1, 1'b0, 32'h400, 1'b0, 32'h0, 1'b0, 32'h404,
          1'b1, 32'h240, 10'h040, 1'b0, 1'b0, 32'h404);
    // 15 EX branch fields without ex_valid have no effect
    drive(1'b0, 32'h1100, 32'h240, 1'b0, 1'b1, 32'h100, 1'b1, 32'h777, 1'b0, 32'h104,
          1'b0, 32'h1104, 10'h040, 1'b0, 1'b0, 32'h104);
    // 16 PC+4 wraps
    fetch(32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0, 10'h3FF);
    // 17 reset asserted: outputs still reflect the table until the edge
    drive(1'b1, 32'h100, 32'h240, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
          1'b1, 32'h240, 10'h040, 1'b0, 1'b0, 32'h4);
`ifdef BP_STATS_EN
    n_checks++;
    if (br_cnt !== 32'd6 || mp_cnt !== 32'd6) begin
      n_errors++;
      $display("FAIL stats_pre_reset: got br=%0d mp=%0d, want br=6 mp=6", br_cnt, mp_cnt);
    end
`endif
    // 18 after reset the table is cleared
    fetch(32'h100, 32'h240, 1'b0, 32'h104, 10'h040);
`ifdef BP_STATS_EN
    n_checks++;
    if (br_cnt !== 32'd0 || mp_cnt !== 32'd0) begin
      n_errors++;
      $display("FAIL stats_after_reset: got br=%0d mp=%0d, want br=0 mp=0", br_cnt, mp_cnt);
    end
`endif

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
